// File: rtl/pong_pkg.sv
// Shared definitions for the pong game blocks: sequencer state encoding and
// timing defaults derived from the system clock frequency.
package pong_pkg;

    // Countdown sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // System clock frequency in Hz.
    localparam int CLK_HZ = 100_000_000;

    // One displayed value per second at the system clock rate.
    localparam int DEFAULT_TICKS_PER_STEP = CLK_HZ;

    // True when a count value is the last nonzero step, so the next decrement ends the countdown.
    function automatic logic is_last_step(input logic [31:0] count_value);
        return (count_value == 32'd1);
    endfunction

endpackage

// File: rtl/countdown_timer_step_timer.sv
// Step prescaler: counts enabled cycles from 0 to TICKS_PER_STEP-1 and flags the
// wrap cycle. The count is preserved while enable is low, so a paused step
// resumes where it left off; clear restarts the step from zero.
module step_timer
    import pong_pkg::*;
#(
    parameter int TICKS_PER_STEP = DEFAULT_TICKS_PER_STEP,
    parameter int TICK_W         = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic wrap
);

    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICKS_PER_STEP - 1);

    logic [TICK_W-1:0] tick_cnt_r;
    logic              at_last_s;

    // Decode the final cycle of a step; only meaningful while counting.
    always_comb begin
        at_last_s = 1'b0;
        wrap      = 1'b0;
        if (tick_cnt_r == LAST_TICK) begin
            at_last_s = 1'b1;
        end else begin
            at_last_s = 1'b0;
        end
        if (enable && at_last_s) begin
            wrap = 1'b1;
        end else begin
            wrap = 1'b0;
        end
    end

    // Cycle counter: restart on reset/clear, advance or wrap when enabled, otherwise freeze.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else if (enable) begin
            if (at_last_s) begin
                tick_cnt_r <= {TICK_W{1'b0}};
            end else begin
                tick_cnt_r <= tick_cnt_r + TICK_W'(1);
            end
        end else begin
            tick_cnt_r <= tick_cnt_r;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Countdown sequencer: on a start event shows START, START-1, ... 0, holding each
// value for TICKS_PER_STEP cycles. Supports hold/resume, abort, optional
// retrigger and one-cycle step/done pulses. All outputs are registered.
module countdown_timer
    import pong_pkg::*;
#(
    parameter int COUNT_W        = 2,
    parameter int START          = 3,
    parameter int TICKS_PER_STEP = DEFAULT_TICKS_PER_STEP,
    parameter int TICK_W         = 27,
    parameter bit RESET_START    = 1'b1,
    parameter bit RETRIGGER      = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_tick,
    input  logic               hold,
    input  logic               abort,
    output logic [COUNT_W-1:0] count,
    output logic               active,
    output logic               holding,
    output logic               step_tick,
    output logic               done
);

    localparam logic [COUNT_W-1:0] START_VAL = COUNT_W'(START);
    localparam logic [COUNT_W-1:0] ZERO_VAL  = {COUNT_W{1'b0}};

    state_t state_r;
    logic   start_accept_s;
    logic   timer_clear_s;
    logic   timer_enable_s;
    logic   wrap_s;

    // Decide whether a start request is honoured and how the prescaler should behave this cycle.
    always_comb begin
        start_accept_s = 1'b0;
        timer_clear_s  = 1'b0;
        timer_enable_s = 1'b0;
        if (start_tick && ((state_r == IDLE) || (RETRIGGER == 1'b1))) begin
            start_accept_s = 1'b1;
        end else begin
            start_accept_s = 1'b0;
        end
        if (abort || start_accept_s) begin
            timer_clear_s  = 1'b1;
            timer_enable_s = 1'b0;
        end else if ((state_r == RUN) && !hold) begin
            timer_clear_s  = 1'b0;
            timer_enable_s = 1'b1;
        end else begin
            timer_clear_s  = 1'b0;
            timer_enable_s = 1'b0;
        end
    end

    step_timer #(
        .TICKS_PER_STEP (TICKS_PER_STEP),
        .TICK_W         (TICK_W)
    ) u_step_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear_s),
        .enable (timer_enable_s),
        .wrap   (wrap_s)
    );

    // Sequencer FSM with count register and registered status/pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= RESET_START ? RUN : IDLE;
            count     <= RESET_START ? START_VAL : ZERO_VAL;
            active    <= RESET_START;
            holding   <= 1'b0;
            step_tick <= 1'b0;
            done      <= 1'b0;
        end else begin
            step_tick <= 1'b0;
            done      <= 1'b0;
            if (abort) begin
                state_r <= IDLE;
                count   <= ZERO_VAL;
                active  <= 1'b0;
                holding <= 1'b0;
            end else if (start_accept_s) begin
                state_r <= hold ? HOLD : RUN;
                count   <= START_VAL;
                active  <= 1'b1;
                holding <= hold;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                        count   <= ZERO_VAL;
                        active  <= 1'b0;
                        holding <= 1'b0;
                    end
                    RUN: begin
                        if (hold) begin
                            state_r <= HOLD;
                            holding <= 1'b1;
                        end else if (wrap_s) begin
                            count     <= count - COUNT_W'(1);
                            step_tick <= 1'b1;
                            if (is_last_step(32'(count))) begin
                                state_r <= IDLE;
                                active  <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                state_r <= RUN;
                            end
                        end else begin
                            state_r <= RUN;
                        end
                    end
                    HOLD: begin
                        if (!hold) begin
                            state_r <= RUN;
                            holding <= 1'b0;
                        end else begin
                            state_r <= HOLD;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        count   <= ZERO_VAL;
                        active  <= 1'b0;
                        holding <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: two instances share stimulus. Instance A starts out
// of reset and ignores retrigger; instance B idles out of reset and retriggers.
// A behavioural model of the countdown rules predicts both.
module tb_countdown_timer;

    localparam int TPS = 4;
    localparam int STV = 3;

    logic clk = 1'b0;
    logic reset, start_tick, hold, abort;
    logic [1:0] count_a, count_b;
    logic active_a, holding_a, step_a, done_a;
    logic active_b, holding_b, step_b, done_b;
    logic [5:0] obs_a, obs_b;

    int errors = 0;
    int checks = 0;

    // Reference model state, index 0 = instance A, 1 = instance B.
    bit m_rstart [2] = '{1'b1, 1'b0};
    bit m_retrig [2] = '{1'b0, 1'b1};
    int m_count  [2];
    int m_elapsed[2];
    bit m_on     [2];
    bit m_paused [2];
    bit m_step   [2];
    bit m_done   [2];

    always #5 clk = ~clk;

    assign obs_a = {count_a, active_a, holding_a, step_a, done_a};
    assign obs_b = {count_b, active_b, holding_b, step_b, done_b};

    countdown_timer #(.COUNT_W(2), .START(STV), .TICKS_PER_STEP(TPS), .TICK_W(3),
                      .RESET_START(1'b1), .RETRIGGER(1'b0)) dut_a (
        .clk(clk), .reset(reset), .start_tick(start_tick), .hold(hold), .abort(abort),
        .count(count_a), .active(active_a), .holding(holding_a),
        .step_tick(step_a), .done(done_a));

    countdown_timer #(.COUNT_W(2), .START(STV), .TICKS_PER_STEP(TPS), .TICK_W(3),
                      .RESET_START(1'b0), .RETRIGGER(1'b1)) dut_b (
        .clk(clk), .reset(reset), .start_tick(start_tick), .hold(hold), .abort(abort),
        .count(count_b), .active(active_b), .holding(holding_b),
        .step_tick(step_b), .done(done_b));

    function automatic logic [5:0] exp_vec(input int i);
        logic [1:0] c;
        c = 2'(m_count[i]);
        return {c, m_on[i], m_paused[i], m_step[i], m_done[i]};
    endfunction

    // Apply the countdown rules for one clock edge to both model instances.
    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            m_step[i] = 1'b0;
            m_done[i] = 1'b0;
            if (reset) begin
                m_on[i] = m_rstart[i];
                m_count[i] = m_rstart[i] ? STV : 0;
                m_elapsed[i] = 0;
                m_paused[i] = 1'b0;
            end else if (abort) begin
                m_on[i] = 1'b0;
                m_count[i] = 0;
                m_elapsed[i] = 0;
                m_paused[i] = 1'b0;
            end else if (start_tick && (!m_on[i] || m_retrig[i])) begin
                m_on[i] = 1'b1;
                m_count[i] = STV;
                m_elapsed[i] = 0;
                m_paused[i] = hold;
            end else if (m_on[i] && m_paused[i]) begin
                if (!hold) m_paused[i] = 1'b0;
            end else if (m_on[i]) begin
                if (hold) begin
                    m_paused[i] = 1'b1;
                end else if (m_elapsed[i] + 1 == TPS) begin
                    m_elapsed[i] = 0;
                    m_count[i] = m_count[i] - 1;
                    m_step[i] = 1'b1;
                    if (m_count[i] == 0) begin
                        m_on[i] = 1'b0;
                        m_done[i] = 1'b1;
                    end
                end else begin
                    m_elapsed[i] = m_elapsed[i] + 1;
                end
            end
        end
    endtask

    // One clock edge; outputs are stable 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start_tick = 1'b0; hold = 1'b0; abort = 1'b0;
        tick();
        tick();
        checks++;
        if (obs_a !== 6'b111000) begin
            errors++; $display("FAIL reset_a: got %b expected %b", obs_a, 6'b111000);
        end
        checks++;
        if (obs_b !== 6'b000000) begin
            errors++; $display("FAIL reset_b: got %b expected %b", obs_b, 6'b000000);
        end
    endtask

    task automatic test_natural_countdown();
        logic [1:0] ec;
        reset = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) tick();
            ec = 2'(STV - k / TPS);
            checks++;
            if (count_a !== ec || step_a !== (k > 0 && k % TPS == 0) ||
                done_a !== (k == 12) || active_a !== (k < 12)) begin
                errors++;
                $display("FAIL natural k=%0d: got cnt=%0d stp=%b dn=%b act=%b expected cnt=%0d",
                         k, count_a, step_a, done_a, active_a, ec);
            end
            checks++;
            if (obs_b !== exp_vec(1)) begin
                errors++; $display("FAIL natural_b k=%0d: got %b expected %b", k, obs_b, exp_vec(1));
            end
        end
    endtask

    task automatic test_start_from_idle();
        start_tick = 1'b1;
        tick();
        start_tick = 1'b0;
        checks++;
        if (count_b !== 2'd3 || active_b !== 1'b1) begin
            errors++; $display("FAIL start_b: got cnt=%0d act=%b expected cnt=3 act=1", count_b, active_b);
        end
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
                errors++; $display("FAIL start_run k=%0d: got %b/%b expected %b/%b",
                                   k, obs_a, obs_b, exp_vec(0), exp_vec(1));
            end
        end
        checks++;
        if (count_b !== 2'd0 || done_b !== 1'b1 || active_b !== 1'b0) begin
            errors++; $display("FAIL start_done: got cnt=%0d dn=%b act=%b expected 0/1/0", count_b, done_b, active_b);
        end
    endtask

    task automatic test_hold();
        start_tick = 1'b1;
        tick();
        start_tick = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        hold = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (count_b !== 2'd2 || holding_b !== 1'b1 || obs_a !== exp_vec(0)) begin
                errors++; $display("FAIL hold k=%0d: got cnt=%0d hld=%b a=%b expected cnt=2 hld=1 a=%b",
                                   k, count_b, holding_b, obs_a, exp_vec(0));
            end
        end
        hold = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (count_b !== ((k < 2) ? 2'd2 : 2'd1) || holding_b !== 1'b0 || obs_b !== exp_vec(1)) begin
                errors++; $display("FAIL resume k=%0d: got %b expected %b", k, obs_b, exp_vec(1));
            end
        end
    endtask

    task automatic test_abort();
        abort = 1'b1; tick(); abort = 1'b0;
        start_tick = 1'b1; tick(); start_tick = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (count_a !== 2'd2 || count_b !== 2'd2) begin
            errors++; $display("FAIL abort_pre: got %0d/%0d expected 2/2", count_a, count_b);
        end
        abort = 1'b1; tick(); abort = 1'b0;
        checks++;
        if (obs_a !== 6'b000000 || obs_b !== 6'b000000) begin
            errors++; $display("FAIL abort: got %b/%b expected 000000", obs_a, obs_b);
        end
        abort = 1'b1; start_tick = 1'b1; tick(); abort = 1'b0; start_tick = 1'b0;
        tick();
        checks++;
        if (obs_a !== 6'b000000 || obs_b !== 6'b000000) begin
            errors++; $display("FAIL abort_start: got %b/%b expected 000000", obs_a, obs_b);
        end
    endtask

    task automatic test_retrigger();
        start_tick = 1'b1; tick(); start_tick = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        start_tick = 1'b1; tick(); start_tick = 1'b0;
        checks++;
        if (count_b !== 2'd3 || count_a !== 2'd1 || step_b !== 1'b0 || done_b !== 1'b0) begin
            errors++; $display("FAIL retrig: got a=%0d b=%0d expected a=1 b=3", count_a, count_b);
        end
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
                errors++; $display("FAIL retrig_run k=%0d: got %b/%b expected %b/%b",
                                   k, obs_a, obs_b, exp_vec(0), exp_vec(1));
            end
            if (k == 3) begin
                checks++;
                if (done_a !== 1'b1) begin
                    errors++; $display("FAIL retrig_a_done: got %b expected 1", done_a);
                end
            end
        end
        checks++;
        if (count_b !== 2'd0 || done_b !== 1'b1) begin
            errors++; $display("FAIL retrig_done: got cnt=%0d dn=%b expected 0/1", count_b, done_b);
        end
        // Final decrement coinciding with a start request.
        start_tick = 1'b1; tick(); start_tick = 1'b0;
        for (int k = 0; k < 11; k++) tick();
        start_tick = 1'b1; tick(); start_tick = 1'b0;
        checks++;
        if (obs_a !== 6'b000011 || obs_b !== 6'b111000) begin
            errors++; $display("FAIL coincide: got %b/%b expected 000011/111000", obs_a, obs_b);
        end
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic test_reset_midcount();
        start_tick = 1'b1; tick(); start_tick = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        hold = 1'b1; tick();
        checks++;
        if (count_a !== 2'd1 || holding_a !== 1'b1) begin
            errors++; $display("FAIL mid_hold: got cnt=%0d hld=%b expected 1/1", count_a, holding_a);
        end
        reset = 1'b1; tick(); reset = 1'b0; hold = 1'b0;
        checks++;
        if (obs_a !== 6'b111000 || obs_b !== 6'b000000) begin
            errors++; $display("FAIL mid_reset: got %b/%b expected 111000/000000", obs_a, obs_b);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (count_a !== ((k < 4) ? 2'd3 : 2'd2) || holding_a !== 1'b0 || obs_a !== exp_vec(0)) begin
                errors++; $display("FAIL mid_restart k=%0d: got %b expected %b", k, obs_a, exp_vec(0));
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            reset      = ($urandom_range(0, 99) == 0);
            abort      = ($urandom_range(0, 39) == 0);
            start_tick = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 9) == 0) hold = ~hold;
            tick();
            checks++;
            if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
                errors++; $display("FAIL random k=%0d: got %b/%b expected %b/%b",
                                   k, obs_a, obs_b, exp_vec(0), exp_vec(1));
            end
        end
        reset = 1'b0; abort = 1'b0; start_tick = 1'b0; hold = 1'b0;
    endtask

    initial begin
        test_reset();
        test_natural_countdown();
        test_start_from_idle();
        test_hold();
        test_abort();
        test_retrigger();
        test_reset_midcount();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Parametrised countdown sequencer; next generation of the pause-countdown FSM.
- On a start event, steps an output value from START down to 0, holding each value for TICKS_PER_STEP clock cycles.
- Adds hold/resume, abort, a configurable retrigger policy and per-step/done pulses.
- Drives the on-screen countdown digit and gates game motion while active.

Parameters:
- COUNT_W, 2, width of count output; must satisfy START <= 2**COUNT_W-1.
- START, 3, first value displayed; must be >= 1.
- TICKS_PER_STEP, 100_000_000, clock cycles each value is held (1 s at 100 MHz); must be >= 2.
- TICK_W, 27, width of the internal cycle counter; must satisfy TICKS_PER_STEP-1 <= 2**TICK_W-1.
- RESET_START, 1, 1 = countdown begins out of reset; 0 = idle out of reset.
- RETRIGGER, 0, 1 = start_tick during a countdown restarts it; 0 = start_tick ignored while active.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_tick  in  1  one-cycle request to begin a countdown
- hold  in  1  level; freezes the countdown while high
- abort  in  1  one-cycle request to cancel the countdown
- count  out  COUNT_W  current countdown value; 0 when idle
- active  out  1  high while in RUN or HOLD
- holding  out  1  high while in HOLD
- step_tick  out  1  one-cycle pulse on every decrement, including the final one
- done  out  1  one-cycle pulse when count reaches 0 naturally

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on posedge clk.
- All outputs are registered.
- Reset values, RESET_START=1: state RUN, count=START, tick_cnt=0, active=1.
- Reset values, RESET_START=0: state IDLE, count=0, tick_cnt=0, active=0.
- Reset values, both cases: holding=0, step_tick=0, done=0.
- States: IDLE, RUN, HOLD.
- Per-cycle priority: reset > abort > start_tick > hold > tick advance.

- IDLE:
  - count=0.
  - start_tick: next cycle count=START, tick_cnt=0; state HOLD if hold=1, else RUN.
  - Otherwise stay.

- RUN:
  - tick_cnt increments each cycle.
  - When tick_cnt==TICKS_PER_STEP-1: tick_cnt<=0, count<=count-1, and step_tick=1 in the cycle the new count appears.
  - If the new count is 0: state IDLE, done=1 in that same cycle.
  - hold=1 (no higher-priority event): next state HOLD; tick_cnt and count frozen, no advance that cycle.

- HOLD:
  - tick_cnt and count frozen; holding=1.
  - hold=0: back to RUN, resuming from the preserved tick_cnt (no restart of the current step).

- start_tick while RUN or HOLD:
  - RETRIGGER=1: reload count=START, tick_cnt=0; next state per hold. No done or step_tick pulse.
  - RETRIGGER=0: ignored.

- abort in any state: next cycle IDLE, count=0, tick_cnt=0; no done or step_tick pulse. abort with start_tick in the same cycle: abort wins.

- Timing: an uninterrupted countdown keeps each value for exactly TICKS_PER_STEP cycles. count==0 appears START*TICKS_PER_STEP cycles after count first shows START.
- A final decrement coinciding with a start_tick:
  - RETRIGGER=1: reload wins, no done pulse.
  - RETRIGGER=0: done fires and the start_tick is dropped.
- step_tick and done are never asserted in IDLE except the single cycle of entry.
- Reset mid-countdown: immediately takes the reset values above, regardless of state.

Decomposition:
- Shared package pong_pkg:
  - state enum (IDLE, RUN, HOLD).
  - Default TICKS_PER_STEP constant (CLK_HZ = 100_000_000).
- One natural sub-module, step_timer: the TICK_W prescaler.
  - Inputs: clk, reset, clear, enable.
  - Output: wrap pulse when the count equals TICKS_PER_STEP-1.
- countdown_timer holds the FSM and count register and instantiates step_timer.

Test Plan (TICKS_PER_STEP=4, START=3, COUNT_W=2 unless noted):
- Reset release, RESET_START=1 -> count 3,3,3,3,2,2,2,2,1,1,1,1,0; step_tick at each change; done only with 0; active falls with 0.
- RESET_START=0, reset, then start_tick at cycle 5 -> count=3 and active=1 from cycle 6; count=0 and done=1 at cycle 18.
- hold high for 10 cycles after 2 cycles at count=2 -> count stays 2, holding=1; after release, 2 more cycles at 2, then 1.
- abort while count=2 -> next cycle count=0, active=0, no done; abort+start_tick same cycle -> stays IDLE.
- RETRIGGER=1, start_tick while count=1 -> count=3, full 12-cycle countdown; with RETRIGGER=0 the same stimulus is ignored.
- Reset asserted at count=1 with hold=1 -> next cycle count=3, holding=0, tick_cnt restarted.
